bmp_stream_decoder: RTL and testbench

- Read-side counterpart to the SD-card BMP save path.
- Consumes the raw byte stream of a 24-bit BMP file, as delivered by the SD sector reader, and parses and validates the header.
- Skips to the pixel array, strips row padding, and emits RGB565 pixels with x/y coordinates for the frame write path into SDRAM (page_up/page_down playback).
- Sits on sd_card_clk between the SD sector reader and the frame write FIFO.

---
 rtl/bmp_stream_decoder_if.sv | 26 ++
 rtl/bmp_stream_decoder.sv | 245 ++++++++++++++++++++++++
 tb/tb_bmp_stream_decoder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmp_stream_decoder_if.sv
// Byte-in / pixel-out stream bundle for the BMP decoder.
// master = stream environment, slave = decoder.
interface bmp_stream_decoder_if #(
  parameter int COORD_W = 12
) ();
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               pixel_valid;
  logic               pixel_ready;
  logic [15:0]        pixel_data;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;

  modport master (
    output byte_valid, byte_data, pixel_ready,
    input  byte_ready, pixel_valid, pixel_data,
    input  pixel_x, pixel_y
  );

  modport slave (
    input  byte_valid, byte_data, pixel_ready,
    output byte_ready, pixel_valid, pixel_data,
    output pixel_x, pixel_y
  );
endinterface

// File: rtl/bmp_stream_decoder.sv
// 24-bit BMP byte stream to RGB565 pixel stream with x/y.
// Option BMP_TOPDOWN_EN: accept negative height as top-down.
module bmp_stream_decoder #(
  parameter int MAX_WIDTH  = 1024,
  parameter int MAX_HEIGHT = 768,
  parameter int COORD_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  bmp_stream_decoder_if.slave bus,
  output logic [COORD_W-1:0] img_width,
  output logic [COORD_W-1:0] img_height,
  output logic               header_ok,
  output logic               frame_done,
  output logic               err,
  output logic [2:0]         err_code
);

  typedef enum logic [2:0] {
    IDLE, HEADER, SKIP, PIXEL, PAD, DONE, ERROR
  } state_t;

  state_t             state;
  logic [31:0]        idx;
  logic [31:0]        off_r;
  logic [31:0]        wid_r;
  logic [31:0]        hgt_r;
  logic [31:0]        comp_r;
  logic [15:0]        bpp_r;
  logic [7:0]         sig0;
  logic [7:0]         b_r;
  logic [7:0]         g_r;
  logic [1:0]         phase;
  logic [1:0]         pad_cnt;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               topdown;
  logic               last_pend;

  logic        acc;
  logic        pix_take;
  logic [7:0]  d;
  logic [1:0]  lane;
  logic [31:0] comp_full;
  logic        hneg;
  logic [31:0] hmag;
  logic        neg_bad;
  logic        size_bad;
  logic [2:0]  hdr_code;
  logic        last_col;
  logic        last_row;
  logic [15:0] pix_word;

  assign bus.byte_ready =
    !(bus.pixel_valid && !bus.pixel_ready);
  assign acc      = bus.byte_valid && bus.byte_ready;
  assign pix_take = bus.pixel_valid && bus.pixel_ready;
  assign d        = bus.byte_data;

  // 32-bit fields start at byte index with [1:0]==2
  assign lane      = idx[1:0] - 2'd2;
  assign comp_full = {d, comp_r[23:0]};
  assign hneg      = hgt_r[31];
  assign hmag      = hneg ? (~hgt_r + 32'd1) : hgt_r;

`ifdef BMP_TOPDOWN_EN
  assign neg_bad = 1'b0;
`else
  assign neg_bad = hneg;
`endif

  assign size_bad = (wid_r == 32'd0)
                 || (wid_r > 32'(MAX_WIDTH))
                 || (hgt_r == 32'd0)
                 || (hmag > 32'(MAX_HEIGHT))
                 || neg_bad;

  // header check result, evaluated as byte 33 arrives
  always_comb begin
    hdr_code = 3'd0;
    if (bpp_r != 16'd24)
      hdr_code = 3'd2;
    else if (comp_full != 32'd0)
      hdr_code = 3'd3;
    else if (size_bad)
      hdr_code = 3'd4;
    else if (off_r < 32'd54)
      hdr_code = 3'd5;
  end

  assign last_col = (x == img_width - 1'b1);
  assign last_row = topdown ? (y == img_height - 1'b1)
                            : (y == '0);
  assign pix_word = {d[7:3], g_r[7:2], b_r[7:3]};

  // decoder FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      off_r           <= '0;
      wid_r           <= '0;
      hgt_r           <= '0;
      comp_r          <= '0;
      bpp_r           <= '0;
      sig0            <= '0;
      b_r             <= '0;
      g_r             <= '0;
      phase           <= '0;
      pad_cnt         <= '0;
      x               <= '0;
      y               <= '0;
      topdown         <= 1'b0;
      last_pend       <= 1'b0;
      bus.pixel_valid <= 1'b0;
      bus.pixel_data  <= '0;
      bus.pixel_x     <= '0;
      bus.pixel_y     <= '0;
      img_width       <= '0;
      img_height      <= '0;
      header_ok       <= 1'b0;
      frame_done      <= 1'b0;
      err             <= 1'b0;
      err_code        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (pix_take) begin
        bus.pixel_valid <= 1'b0;
        if (last_pend) begin
          frame_done <= 1'b1;
          last_pend  <= 1'b0;
        end
      end
      if (start) begin
        state           <= HEADER;
        idx             <= '0;
        phase           <= '0;
        pad_cnt         <= '0;
        x               <= '0;
        y               <= '0;
        last_pend       <= 1'b0;
        bus.pixel_valid <= 1'b0;
        header_ok       <= 1'b0;
        frame_done      <= 1'b0;
        err             <= 1'b0;
        err_code        <= '0;
      end else if (acc) begin
        unique case (state)
          HEADER: begin
            idx <= idx + 32'd1;
            unique case (1'b1)
              (idx == 32'd0):
                sig0 <= d;
              (idx >= 32'd10 && idx <= 32'd13):
                off_r[{lane, 3'b000} +: 8] <= d;
              (idx >= 32'd18 && idx <= 32'd21):
                wid_r[{lane, 3'b000} +: 8] <= d;
              (idx >= 32'd22 && idx <= 32'd25):
                hgt_r[{lane, 3'b000} +: 8] <= d;
              (idx == 32'd28):
                bpp_r[7:0] <= d;
              (idx == 32'd29):
                bpp_r[15:8] <= d;
              (idx >= 32'd30 && idx <= 32'd33):
                comp_r[{lane, 3'b000} +: 8] <= d;
              default: ;
            endcase
            if (idx == 32'd1) begin
              if (!(sig0 == 8'h42 && d == 8'h4D)) begin
                state    <= ERROR;
                err      <= 1'b1;
                err_code <= 3'd1;
              end
            end else if (idx == 32'd33) begin
              if (hdr_code != 3'd0) begin
                state    <= ERROR;
                err      <= 1'b1;
                err_code <= hdr_code;
              end else begin
                header_ok  <= 1'b1;
                img_width  <= wid_r[COORD_W-1:0];
                img_height <= hmag[COORD_W-1:0];
                topdown    <= hneg;
                x          <= '0;
                y          <= hneg ? '0
                              : COORD_W'(hmag - 32'd1);
                phase      <= '0;
                state      <= (off_r == 32'd34) ? PIXEL
                                                : SKIP;
              end
            end
          end
          SKIP: begin
            idx <= idx + 32'd1;
            if (idx == off_r - 32'd1)
              state <= PIXEL;
          end
          PIXEL: begin
            unique case (phase)
              2'd0: begin
                b_r   <= d;
                phase <= 2'd1;
              end
              2'd1: begin
                g_r   <= d;
                phase <= 2'd2;
              end
              default: begin
                phase           <= 2'd0;
                bus.pixel_valid <= 1'b1;
                bus.pixel_data  <= pix_word;
                bus.pixel_x     <= x;
                bus.pixel_y     <= y;
                if (last_col) begin
                  x <= '0;
                  if (last_row) begin
                    last_pend <= 1'b1;
                    state     <= DONE;
                  end else begin
                    y <= topdown ? y + 1'b1
                                 : y - 1'b1;
                    if (img_width[1:0] != 2'd0) begin
                      pad_cnt <= img_width[1:0];
                      state   <= PAD;
                    end
                  end
                end else begin
                  x <= x + 1'b1;
                end
              end
            endcase
          end
          PAD: begin
            pad_cnt <= pad_cnt - 2'd1;
            if (pad_cnt == 2'd1)
              state <= PIXEL;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmp_stream_decoder.sv
// Self-checking bench for bmp_stream_decoder.
// Random files checked against a file-level reference model.
module tb_bmp_stream_decoder;

  localparam int CW = 12;
`ifdef BMP_TOPDOWN_EN
  localparam bit TD = 1'b1;
`else
  localparam bit TD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] img_width;
  logic [CW-1:0] img_height;
  logic          header_ok;
  logic          frame_done;
  logic          err;
  logic [2:0]    err_code;

  bmp_stream_decoder_if #(.COORD_W(CW)) bus ();

  bmp_stream_decoder #(
    .MAX_WIDTH(1024), .MAX_HEIGHT(768), .COORD_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bus(bus),
    .img_width(img_width), .img_height(img_height),
    .header_ok(header_ok), .frame_done(frame_done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fq[$];
  logic [39:0] got[$];
  logic [39:0] exp_q[$];
  int fd_cnt, stall_bad, stall_seen, stall_total;
  int pv_seen, timeout;

  function automatic logic [31:0] le32(int p);
    return {fq[p+3], fq[p+2], fq[p+1], fq[p]};
  endfunction

  task automatic set32(int p, logic [31:0] v);
    for (int i = 0; i < 4; i++) fq[p+i] = v[8*i +: 8];
  endtask

  task automatic build(int w, int h, int off, int bpp,
                       int comp, logic [7:0] s1);
    int hdr, ha, n;
    logic [31:0] bv;
    fq.delete();
    hdr = (off > 54) ? off : 54;
    for (int i = 0; i < hdr; i++) fq.push_back(8'($urandom));
    fq[0] = 8'h42;
    fq[1] = s1;
    set32(10, off);
    set32(14, 32'd40);
    set32(18, w);
    set32(22, h);
    fq[26] = 8'd1;
    fq[27] = 8'd0;
    bv = bpp;
    fq[28] = bv[7:0];
    fq[29] = bv[15:8];
    set32(30, comp);
    ha = (h < 0) ? -h : h;
    n = 0;
    if (w >= 1 && w <= 64 && ha <= 16) n = ha * (w * 3 + w % 4);
    for (int i = 0; i < n + 8; i++) fq.push_back(8'($urandom));
  endtask

  // expected error code from the header fields of fq
  function automatic int model_code();
    logic [31:0] off, w, h, comp;
    logic [15:0] bpp;
    int hs, ha;
    if (fq[0] != 8'h42 || fq[1] != 8'h4D) return 1;
    off  = le32(10);
    w    = le32(18);
    h    = le32(22);
    comp = le32(30);
    bpp  = {fq[29], fq[28]};
    hs   = $signed(h);
    ha   = (hs < 0) ? -hs : hs;
    if (bpp != 16'd24) return 2;
    if (comp != 0) return 3;
    if (w == 0 || w > 1024 || hs == 0 || ha > 768 || (hs < 0 && !TD))
      return 4;
    if (off < 54) return 5;
    return 0;
  endfunction

  // expected pixel stream: {x, y, rgb565} in output order
  task automatic model_pixels();
    int off, w, hs, ha, stride, p, yy;
    logic [7:0] b, g, r;
    exp_q.delete();
    if (model_code() != 0) return;
    off = int'(le32(10));
    w   = int'(le32(18));
    hs  = $signed(le32(22));
    ha  = (hs < 0) ? -hs : hs;
    stride = w * 3 + w % 4;
    for (int row = 0; row < ha; row++) begin
      yy = (hs < 0) ? row : ha - 1 - row;
      for (int c = 0; c < w; c++) begin
        p = off + row * stride + 3 * c;
        b = fq[p];
        g = fq[p+1];
        r = fq[p+2];
        exp_q.push_back({CW'(c), CW'(yy), r[7:3], g[7:2], b[7:3]});
      end
    end
  endtask

  task automatic do_start(bit bv);
    @(negedge clk);
    start = 1'b1;
    bus.byte_valid = bv;
    bus.byte_data = 8'($urandom);
    bus.pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.pixel_ready = 1'b0;
  endtask

  // stream the first n bytes of fq and collect pixels
  task automatic play(int n, int vprob, int rprob);
    int idx, cyc, idle;
    idx = 0; cyc = 0; idle = 0;
    got.delete();
    fd_cnt = 0; stall_bad = 0; stall_seen = 0;
    pv_seen = 0; timeout = 0;
    while (idle < 30) begin
      @(negedge clk);
      bus.byte_valid = (idx < n) && ($urandom_range(0, 99) < vprob);
      bus.byte_data = (idx < n) ? fq[idx] : 8'h00;
      bus.pixel_ready = ($urandom_range(0, 99) < rprob);
      #1;
      if (bus.byte_valid && bus.byte_ready) idx++;
      if (bus.pixel_valid) pv_seen++;
      if (bus.pixel_valid && bus.pixel_ready)
        got.push_back({bus.pixel_x, bus.pixel_y, bus.pixel_data});
      if (bus.pixel_valid && !bus.pixel_ready) begin
        stall_seen++;
        if (bus.byte_ready) stall_bad++;
      end
      if (frame_done) fd_cnt++;
      if (idx >= n) idle++;
      cyc++;
      if (cyc > n * 20 + 500) begin
        timeout = 1;
        break;
      end
    end
    stall_total += stall_seen;
    bus.byte_valid = 1'b0;
    bus.pixel_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_byte_ready got %b want 1", bus.byte_ready);
    end
    checks++;
    if ({bus.pixel_valid, header_ok, frame_done, err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.pixel_valid, header_ok, frame_done, err});
    end
    checks++;
    if ({err_code, bus.pixel_data, bus.pixel_x, bus.pixel_y,
         img_width, img_height} !== '0) begin
      errors++;
      $display("FAIL reset_values got code %0d data %h w %0d h %0d want 0",
               err_code, bus.pixel_data, img_width, img_height);
    end
  endtask

  task automatic test_basic();
    build(3, 2, 54, 24, 0, 8'h4D);
    fq[54] = 8'hFF; fq[55] = 8'h00; fq[56] = 8'h80;
    model_pixels();
    do_start(1'b0);
    play(fq.size(), 100, 100);
    checks++;
    if (timeout != 0 || got.size() != 6) begin
      errors++;
      $display("FAIL basic_count got %0d want 6 (timeout %0d)",
               got.size(), timeout);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_pix%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (got.size() == 0 || got[0][15:0] !== 16'h801F) begin
      errors++;
      $display("FAIL basic_pack got %h want 801f",
               (got.size() > 0) ? got[0][15:0] : 16'hxxxx);
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL basic_frame_done got %0d pulses want 1", fd_cnt);
    end
    checks++;
    if ({header_ok, err, img_width, img_height} !==
        {1'b1, 1'b0, CW'(3), CW'(2)}) begin
      errors++;
      $display("FAIL basic_header got ok %b err %b w %0d h %0d want 1 0 3 2",
               header_ok, err, img_width, img_height);
    end
  endtask

  task automatic test_skip();
    build(2, 2, 58, 24, 0, 8'h4D);
    for (int i = 54; i < 58; i++) fq[i] = 8'hAA;
    model_pixels();
    do_start(1'b0);
    play(fq.size(), 70, 100);
    checks++;
    if (timeout != 0 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL skip_count got %0d want %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL skip_pix%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_sig();
    int code;
    build(2, 2, 54, 24, 0, 8'h4E);
    code = model_code();
    do_start(1'b0);
    play(fq.size(), 100, 100);
    checks++;
    if (err !== 1'b1 || int'(err_code) != code || pv_seen != 0) begin
      errors++;
      $display("FAIL sig_err got err %b code %0d pix %0d want 1 %0d 0",
               err, err_code, pv_seen, code);
    end
    build(4, 3, 54, 24, 0, 8'h4D);
    model_pixels();
    do_start(1'b0);
    play(fq.size(), 80, 80);
    checks++;
    if (err !== 1'b0 || got.size() != exp_q.size() || fd_cnt != 1) begin
      errors++;
      $display("FAIL sig_recover got err %b n %0d fd %0d want 0 %0d 1",
               err, got.size(), exp_q.size(), fd_cnt);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sig_pix%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_header_errors();
    int bpp_t[4]  = '{16, 24, 24, 24};
    int comp_t[4] = '{0, 1, 0, 0};
    int w_t[4]    = '{2, 2, 1025, 2};
    int off_t[4]  = '{54, 54, 54, 40};
    int code;
    for (int k = 0; k < 4; k++) begin
      build(w_t[k], 2, off_t[k], bpp_t[k], comp_t[k], 8'h4D);
      code = model_code();
      do_start(1'b0);
      play(fq.size(), 80, 100);
      checks++;
      if (err !== 1'b1 || int'(err_code) != code ||
          header_ok !== 1'b0 || pv_seen != 0) begin
        errors++;
        $display("FAIL hdr_err%0d got err %b code %0d ok %b want 1 %0d 0",
                 k, err, err_code, header_ok, code);
      end
    end
  endtask

  task automatic test_stall();
    int w, h, off;
    for (int it = 0; it < 6; it++) begin
      w = $urandom_range(1, 7);
      h = $urandom_range(1, 5);
      off = 54 + $urandom_range(0, 6);
      build(w, h, off, 24, 0, 8'h4D);
      model_pixels();
      for (int pass = 0; pass < 2; pass++) begin
        do_start(1'b0);
        if (pass == 0) play(fq.size(), 100, 100);
        else play(fq.size(), 60, 50);
        checks++;
        if (timeout != 0 || got.size() != exp_q.size() ||
            fd_cnt != 1 || stall_bad != 0) begin
          errors++;
          $display("FAIL stall%0d_%0d got n %0d fd %0d bad %0d want %0d 1 0",
                   it, pass, got.size(), fd_cnt, stall_bad, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
          checks++;
          if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall%0d_%0d pix%0d got %h want %h",
                     it, pass, i, got[i], exp_q[i]);
          end
        end
      end
    end
    checks++;
    if (stall_total == 0) begin
      errors++;
      $display("FAIL stall_seen got 0 stalled cycles want >0");
    end
  endtask

  task automatic test_topdown();
    int code;
    build(3, -2, 54, 24, 0, 8'h4D);
    code = model_code();
    model_pixels();
    do_start(1'b0);
    play(fq.size(), 80, 70);
    checks++;
    if (int'(err_code) != code || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL topdown got code %0d n %0d want %0d %0d",
               err_code, got.size(), code, exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL topdown_pix%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_restart();
    build(3, 2, 54, 24, 0, 8'h4D);
    do_start(1'b0);
    play(61, 100, 100);
    checks++;
    if (fd_cnt != 0 || header_ok !== 1'b1) begin
      errors++;
      $display("FAIL restart_partial got fd %0d ok %b want 0 1",
               fd_cnt, header_ok);
    end
    do_start(1'b1);
    #1;
    checks++;
    if (header_ok !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got ok %b err %b want 0 0",
               header_ok, err);
    end
    build(4, 1, 54, 24, 0, 8'h4D);
    model_pixels();
    play(fq.size(), 90, 90);
    checks++;
    if (got.size() != 4 || fd_cnt != 1 || timeout != 0) begin
      errors++;
      $display("FAIL restart_count got n %0d fd %0d want 4 1",
               got.size(), fd_cnt);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL restart_pix%0d got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    stall_total = 0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    bus.pixel_ready = 1'b0;
    test_reset();
    test_basic();
    test_skip();
    test_bad_sig();
    test_header_errors();
    test_stall();
    test_topdown();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
